// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: requester-side and AXI read-side signals of the two-port
// read arbiter, bundled so the arbiter and its environment share one definition.
//
// Handshake semantics used throughout this interface:
// - A transfer happens on a rising clk edge where both valid and ready are 1.
// - Once a source raises valid, it holds valid and its payload until that edge.
// - req_ready is a one-cycle, one-hot accept pulse. It may depend on req_valid
//   in the same cycle.
// - m_axi_arvalid and m_axi_rready never depend on the ready or valid input of
//   the same channel.
interface axi_read_arbiter_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  // Requester side: bit/slice 0 = instruction fetcher, 1 = data/memory stage.
  logic [1:0]              req_valid;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [15:0]             req_len;
  logic [1:0]              req_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic [1:0]              resp_valid;
  logic                    resp_last;
  logic                    resp_err;

  // AXI read-address channel.
  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;

  // AXI read-data channel.
  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  // Arbiter's view.
  modport master (
    input  req_valid, req_addr, req_len,
    output req_ready, resp_data, resp_valid, resp_last, resp_err,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  // Environment's view: the requesters and the AXI slave.
  modport slave (
    output req_valid, req_addr, req_len,
    input  req_ready, resp_data, resp_valid, resp_last, resp_err,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read master between an instruction fetcher
// (requester 0) and a data/memory stage (requester 1). At most one burst is
// outstanding at a time.
// FSM: IDLE -> ADDR -> DATA -> IDLE, with at least one IDLE cycle between bursts.
// Optional macro ARB_RR_EN selects round-robin tie breaking. When it is
// undefined, requester 1 wins every tie.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = ADDR, 2 = DATA.
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  axi_read_arbiter_if.master bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;

  // Burst context latched at grant time. Later changes on req_* are ignored.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic                  owner_q;
  logic [8:0]            beat_cnt_q;

  logic                  any_req;
  logic                  winner;
  logic                  accept;
  logic                  ar_fire;
  logic                  beat;
  logic                  in_data;
  logic                  count_bad;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [DATA_WIDTH-1:0] rdata_w;

  // rresp[0] separates OKAY from EXOKAY. Neither value is an error here.
  logic                  unused_rresp0;
  assign unused_rresp0 = bus.m_axi_rresp[0];

`ifdef ARB_RR_EN
  // Requester that received the most recent grant. Reset value 1 makes the
  // first tie after reset go to requester 0.
  logic                  last_grant_q;
`endif

  assign state_dbg = state_q;
  assign in_data   = (state_q == ST_DATA);
  assign any_req   = |bus.req_valid;
  assign accept    = (state_q == ST_IDLE) && any_req;
  assign ar_fire   = (state_q == ST_ADDR) && bus.m_axi_arready;
  assign beat      = in_data && bus.m_axi_rvalid;
  assign cur_id    = ID_WIDTH'(owner_q);
  assign rdata_w   = bus.m_axi_rdata;

  // The counter holds the number of beats already taken before the current
  // beat. "Count including this beat != len+1" is therefore the same test as
  // beat_cnt_q != len.
  assign count_bad = (beat_cnt_q != {1'b0, len_q});

  // Winner selection. A lone requester always wins; ties use the configured policy.
  always_comb begin
    winner = 1'b0;
    case (bus.req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
`ifdef ARB_RR_EN
      2'b11:   winner = ~last_grant_q;
`else
      2'b11:   winner = 1'b1;
`endif
      default: winner = 1'b0;
    endcase
  end

  // State register. Reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_ADDR;
      ST_ADDR: if (bus.m_axi_arready) state_d = ST_DATA;
      ST_DATA: if (bus.m_axi_rvalid && bus.m_axi_rlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the winning request's address, length and owner when it is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      owner_q <= 1'b0;
    end else if (accept) begin
      owner_q <= winner;
      if (winner) begin
        addr_q <= bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
        len_q  <= bus.req_len[15:8];
      end else begin
        addr_q <= bus.req_addr[ADDR_WIDTH-1:0];
        len_q  <= bus.req_len[7:0];
      end
    end
  end

  // Beat counter: cleared when the address is accepted, then advanced once per beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
    end else if (ar_fire) begin
      beat_cnt_q <= '0;
    end else if (beat) begin
      beat_cnt_q <= beat_cnt_q + 9'd1;
    end
  end

`ifdef ARB_RR_EN
  // Record every grant so the next tie goes to the other requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= winner;
    end
  end
`endif

  // Outputs are decoded from state and the latched context.
  // - req_ready is also gated by reset, so no accept pulse can appear while reset is asserted.
  // - The R channel passes straight through to the owning requester, but only in DATA.
  always_comb begin
    bus.req_ready     = 2'b00;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_araddr  = addr_q;
    bus.m_axi_arlen   = len_q;
    bus.m_axi_arid    = cur_id;
    bus.m_axi_rready  = 1'b0;
    bus.resp_data     = rdata_w;
    bus.resp_valid    = 2'b00;
    bus.resp_last     = 1'b0;
    bus.resp_err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req && reset) begin
          bus.req_ready = winner ? 2'b10 : 2'b01;
        end
      end
      ST_ADDR: begin
        bus.m_axi_arvalid = 1'b1;
      end
      ST_DATA: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid) begin
          bus.resp_valid = owner_q ? 2'b10 : 2'b01;
          bus.resp_last  = bus.m_axi_rlast;
          bus.resp_err   = bus.m_axi_rresp[1]
                         || (bus.m_axi_rid != cur_id)
                         || (bus.m_axi_rlast && count_bad);
        end
      end
      default: begin
        bus.req_ready = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed scenarios for axi_read_arbiter. Expected R beats
// go into exp_q when they are driven and are popped when the DUT presents them.
module tb_axi_read_arbiter;
  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int EW  = DW + 4;
  localparam logic [AW-1:0] A0 = 64'h0000_0000_0000_A000;
  localparam logic [AW-1:0] A1 = 64'h0000_0000_0000_B000;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [EW-1:0] exp_q[$];

  axi_read_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic init_inputs();
    bus.req_valid     = 2'b00;
    bus.req_addr      = '0;
    bus.req_len       = '0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rid     = '0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    init_inputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // driver: present one R beat, record the expected response, and check it if the DUT shows it
  task automatic drive_beat(input logic [DW-1:0] data, input logic [1:0] rresp, input logic last,
                            input logic [IDW-1:0] id, input logic [1:0] exp_valid, input logic exp_err,
                            input string tag);
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    bus.m_axi_rdata  = data;
    bus.m_axi_rresp  = rresp;
    bus.m_axi_rlast  = last;
    bus.m_axi_rid    = id;
    bus.m_axi_rvalid = 1'b1;
    exp_q.push_back({exp_valid, last, exp_err, data});
    #1;
    if (bus.resp_valid !== 2'b00) begin
      got = {bus.resp_valid, bus.resp_last, bus.resp_err, bus.resp_data};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL %s_beat got=%h exp=%h", tag, got, exp); end
    end
    @(negedge clk);
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    bus.m_axi_rresp  = 2'b00;
  endtask

  // driver: raise a single request, check its grant, AR issue and entry into DATA
  task automatic open_burst(input logic owner, input logic [AW-1:0] addr, input logic [7:0] len, input string tag);
    logic [1:0] oh;
    oh = owner ? 2'b10 : 2'b01;
    bus.req_valid = oh;
    if (owner) begin
      bus.req_addr[2*AW-1:AW] = addr;
      bus.req_len[15:8]       = len;
    end else begin
      bus.req_addr[AW-1:0] = addr;
      bus.req_len[7:0]     = len;
    end
    bus.m_axi_arready = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== oh) begin n_err++; $display("FAIL %s_req_ready got=%b exp=%b", tag, bus.req_ready, oh); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n_cmp++;
    if ({bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr, bus.m_axi_arlen} !== {1'b1, IDW'(owner), addr, len}) begin
      n_err++;
      $display("FAIL %s_ar got=%b/%h/%h/%h exp=1/%h/%h/%h", tag, bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr,
               bus.m_axi_arlen, IDW'(owner), addr, len);
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({state_dbg, bus.m_axi_rready} !== 3'b101) begin n_err++; $display("FAIL %s_enter_data got=%b exp=101", tag, {state_dbg, bus.m_axi_rready}); end
  endtask

  task automatic test_reset();
    init_inputs();
    reset = 1'b0;
    @(negedge clk);
    bus.req_valid    = 2'b11;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rlast  = 1'b1;
    #1;
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    n_cmp++;
    if ({bus.m_axi_arvalid, bus.m_axi_rready, bus.req_ready, bus.resp_valid, bus.resp_last, bus.resp_err} !== 8'h00) begin
      n_err++;
      $display("FAIL rst_ctrl got=%b exp=0", {bus.m_axi_arvalid, bus.m_axi_rready, bus.req_ready, bus.resp_valid, bus.resp_last, bus.resp_err});
    end
    n_cmp++;
    if ({bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arid} !== '0) begin
      n_err++;
      $display("FAIL rst_ar got=%h/%h/%h exp=0", bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arid);
    end
    @(negedge clk);
    init_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if ({state_dbg, bus.m_axi_arvalid, bus.req_ready} !== 5'b0) begin n_err++; $display("FAIL rst_release got=%b exp=0", {state_dbg, bus.m_axi_arvalid, bus.req_ready}); end
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    apply_reset();
    open_burst(1'b0, 64'h1000, 8'd7, "single");
    for (int i = 0; i < 8; i++) begin
      drive_beat({$urandom, $urandom}, 2'b00, (i == 7), '0, 2'b01, 1'b0, "single");
    end
    #1;
    n_cmp++; if ({state_dbg, bus.resp_valid, bus.m_axi_arvalid} !== 5'b0) begin n_err++; $display("FAIL single_idle got=%b exp=0", {state_dbg, bus.resp_valid, bus.m_axi_arvalid}); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
  endtask

  // one grant/burst cycle with both requesters contending; the winner may drop after its accept
  task automatic grant_round(input logic exp_w, input logic drop, input string tag);
    logic [1:0] oh;
    oh = exp_w ? 2'b10 : 2'b01;
    #1;
    n_cmp++; if (bus.req_ready !== oh) begin n_err++; $display("FAIL %s_grant got=%b exp=%b", tag, bus.req_ready, oh); end
    @(negedge clk);
    if (drop) bus.req_valid[exp_w] = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_axi_arid, bus.m_axi_araddr} !== {IDW'(exp_w), (exp_w ? A1 : A0)}) begin
      n_err++;
      $display("FAIL %s_ar got=%h/%h exp=%h/%h", tag, bus.m_axi_arid, bus.m_axi_araddr, IDW'(exp_w), (exp_w ? A1 : A0));
    end
    @(negedge clk);
    drive_beat({$urandom, $urandom}, 2'b00, 1'b1, IDW'(exp_w), oh, 1'b0, tag);
  endtask

  task automatic test_priority();
    apply_reset();
    bus.req_addr      = {A1, A0};
    bus.req_len       = 16'h0000;
    bus.m_axi_arready = 1'b1;
    bus.req_valid     = 2'b11;
`ifdef ARB_RR_EN
    grant_round(1'b0, 1'b0, "held_g0");
    grant_round(1'b1, 1'b0, "held_g1");
    grant_round(1'b0, 1'b0, "held_g2");
`else
    grant_round(1'b1, 1'b0, "held_g0");
    grant_round(1'b1, 1'b0, "held_g1");
    grant_round(1'b1, 1'b0, "held_g2");
`endif
    bus.req_valid = 2'b00;
    apply_reset();
    bus.req_addr      = {A1, A0};
    bus.req_len       = 16'h0000;
    bus.m_axi_arready = 1'b1;
    bus.req_valid     = 2'b11;
`ifdef ARB_RR_EN
    grant_round(1'b0, 1'b1, "drop_g0");
    grant_round(1'b1, 1'b1, "drop_g1");
`else
    grant_round(1'b1, 1'b1, "drop_g0");
    grant_round(1'b0, 1'b1, "drop_g1");
`endif
    #1;
    n_cmp++; if ({state_dbg, bus.req_ready} !== 4'b0) begin n_err++; $display("FAIL prio_idle got=%b exp=0", {state_dbg, bus.req_ready}); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL prio_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
  endtask

  task automatic test_arready_stall();
    apply_reset();
    bus.m_axi_arready    = 1'b0;
    bus.req_valid        = 2'b01;
    bus.req_addr[AW-1:0] = 64'h2468_ACE0;
    bus.req_len[7:0]     = 8'd3;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL stall_grant got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid    = 2'b00;
    bus.req_addr     = '1;
    bus.req_len      = '1;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rlast  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      n_cmp++;
      if ({bus.m_axi_arvalid, bus.m_axi_rready, bus.resp_valid, bus.m_axi_arlen, bus.m_axi_araddr} !== {1'b1, 1'b0, 2'b00, 8'd3, 64'h2468_ACE0}) begin
        n_err++;
        $display("FAIL stall_c%0d got=%b/%b/%b/%h/%h exp=1/0/00/03/2468ace0", c, bus.m_axi_arvalid, bus.m_axi_rready,
                 bus.resp_valid, bus.m_axi_arlen, bus.m_axi_araddr);
      end
      @(negedge clk);
    end
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_arready = 1'b1;
    #1;
    n_cmp++; if ({state_dbg, bus.m_axi_arvalid} !== 3'b011) begin n_err++; $display("FAIL stall_c6 got=%b exp=011", {state_dbg, bus.m_axi_arvalid}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({state_dbg, bus.m_axi_arvalid, bus.m_axi_rready} !== 4'b1001) begin n_err++; $display("FAIL stall_data got=%b exp=1001", {state_dbg, bus.m_axi_arvalid, bus.m_axi_rready}); end
    for (int i = 0; i < 4; i++) begin
      drive_beat({$urandom, $urandom}, 2'b00, (i == 3), '0, 2'b01, 1'b0, "stall");
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_err_gaps();
    apply_reset();
    open_burst(1'b1, 64'h4000, 8'd3, "gap");
    for (int b = 1; b <= 4; b++) begin
      drive_beat({$urandom, $urandom}, (b == 3) ? 2'b10 : 2'b00, (b == 4), IDW'(1), 2'b10, (b == 3), "gap");
      if (b < 4) begin
        for (int g = 0; g < 2; g++) begin
          bus.m_axi_rdata = {$urandom, $urandom};
          #1;
          n_cmp++;
          if ({bus.resp_valid, bus.resp_last, bus.resp_err} !== 4'b0) begin
            n_err++;
            $display("FAIL gap_b%0d_g%0d got=%b exp=0", b, g, {bus.resp_valid, bus.resp_last, bus.resp_err});
          end
          @(negedge clk);
        end
      end
    end
    #1;
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL gap_idle got=%0d exp=0", state_dbg); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL gap_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
  endtask

  task automatic test_count_err();
    // rlast arrives early (beat 2 of 4), and beat 1 carries a foreign ID
    apply_reset();
    open_burst(1'b0, 64'h6000, 8'd3, "short");
    drive_beat({$urandom, $urandom}, 2'b00, 1'b0, IDW'(5), 2'b01, 1'b1, "short_b1");
    drive_beat({$urandom, $urandom}, 2'b01, 1'b1, '0, 2'b01, 1'b1, "short_b2");
    #1;
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL short_idle got=%0d exp=0", state_dbg); end
    @(negedge clk);
    // rlast arrives late (beat 3 of 2)
    open_burst(1'b1, 64'h7000, 8'd1, "long");
    drive_beat({$urandom, $urandom}, 2'b00, 1'b0, IDW'(1), 2'b10, 1'b0, "long_b1");
    drive_beat({$urandom, $urandom}, 2'b00, 1'b0, IDW'(1), 2'b10, 1'b0, "long_b2");
    drive_beat({$urandom, $urandom}, 2'b00, 1'b1, IDW'(1), 2'b10, 1'b1, "long_b3");
    @(negedge clk);
    // largest burst: 256 beats, counter must not wrap
    open_burst(1'b0, 64'h8000, 8'd255, "max");
    for (int i = 0; i < 256; i++) begin
      drive_beat({$urandom, $urandom}, 2'b00, (i == 255), '0, 2'b01, 1'b0, "max");
    end
    #1;
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL max_idle got=%0d exp=0", state_dbg); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL count_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    open_burst(1'b0, 64'h5000, 8'd7, "rst");
    drive_beat({$urandom, $urandom}, 2'b00, 1'b0, '0, 2'b01, 1'b0, "rst_b1");
    drive_beat({$urandom, $urandom}, 2'b00, 1'b0, '0, 2'b01, 1'b0, "rst_b2");
    bus.m_axi_rdata  = {$urandom, $urandom};
    bus.m_axi_rid    = '0;
    bus.m_axi_rvalid = 1'b1;
    #1;
    n_cmp++; if (bus.resp_valid !== 2'b01) begin n_err++; $display("FAIL rst_b3_pre got=%b exp=01", bus.resp_valid); end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.m_axi_arvalid, bus.m_axi_rready, bus.resp_valid, bus.resp_last, bus.resp_err, bus.req_ready} !== 8'h00) begin
      n_err++;
      $display("FAIL rst_async got=%b exp=0", {bus.m_axi_arvalid, bus.m_axi_rready, bus.resp_valid, bus.resp_last, bus.resp_err, bus.req_ready});
    end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_async_state got=%0d exp=0", state_dbg); end
    @(negedge clk);
    reset                   = 1'b1;
    bus.m_axi_rlast         = 1'b1;
    bus.req_valid           = 2'b10;
    bus.req_addr[2*AW-1:AW] = 64'h3000;
    bus.req_len[15:8]       = 8'd0;
    bus.m_axi_arready       = 1'b1;
    #1;
    n_cmp++; if ({bus.req_ready, bus.resp_valid, bus.m_axi_rready} !== 5'b10000) begin n_err++; $display("FAIL rst_regrant got=%b exp=10000", {bus.req_ready, bus.resp_valid, bus.m_axi_rready}); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n_cmp++;
    if ({bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr, bus.resp_valid, bus.m_axi_rready} !== {1'b1, IDW'(1), 64'h3000, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL rst_new_ar got=%b/%h/%h/%b/%b exp=1/1/3000/00/0", bus.m_axi_arvalid, bus.m_axi_arid, bus.m_axi_araddr,
               bus.resp_valid, bus.m_axi_rready);
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    @(negedge clk);
    drive_beat({$urandom, $urandom}, 2'b00, 1'b1, IDW'(1), 2'b10, 1'b0, "rst_new");
    #1;
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_new_idle got=%0d exp=0", state_dbg); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.m_axi_arready    = 1'b1;
    bus.req_valid        = 2'b01;
    bus.req_addr[AW-1:0] = 64'h9000;
    bus.req_len[7:0]     = 8'd0;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL b2b_g1 got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    // the next request is posted while the first burst is in ADDR and must not disturb it
    bus.req_addr[AW-1:0] = 64'h9100;
    bus.req_len[7:0]     = 8'd2;
    #1;
    n_cmp++;
    if ({bus.m_axi_araddr, bus.m_axi_arlen, bus.req_ready} !== {64'h9000, 8'd0, 2'b00}) begin
      n_err++;
      $display("FAIL b2b_hold got=%h/%h/%b exp=9000/00/00", bus.m_axi_araddr, bus.m_axi_arlen, bus.req_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL b2b_data_ready got=%b exp=00", bus.req_ready); end
    drive_beat({$urandom, $urandom}, 2'b00, 1'b1, '0, 2'b01, 1'b0, "b2b_1");
    #1;
    n_cmp++;
    if ({state_dbg, bus.m_axi_arvalid, bus.req_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL b2b_idle_gap got=%b exp=00001", {state_dbg, bus.m_axi_arvalid, bus.req_ready});
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n_cmp++;
    if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen} !== {1'b1, 64'h9100, 8'd2}) begin
      n_err++;
      $display("FAIL b2b_ar2 got=%b/%h/%h exp=1/9100/02", bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive_beat({$urandom, $urandom}, 2'b00, (i == 2), '0, 2'b01, 1'b0, "b2b_2");
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    reset = 1'b0;
    init_inputs();
    test_reset();
    test_single_burst();
    test_priority();
    test_arready_stall();
    test_err_gaps();
    test_count_err();
    test_reset_midburst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
